// File: rtl/leds_racer_race_core.sv
// rtl/leds_racer_race_core.sv - LEDs racer game core: button sync/debounce and IDLE/RACE/WIN game FSM
// Defining LEDS_RACER_WIN_TIMEOUT_EN adds an automatic return from WIN after WIN_TIMEOUT_CYCLES.
module leds_racer_race_core #(
  parameter int PLAYERS            = 4,
  parameter int MAX_POS            = 44,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int WIN_TIMEOUT_CYCLES = 50000000,
  localparam int PW = $clog2(MAX_POS + 1),
  localparam int WW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  FORCE_RESET,
  input  logic [PLAYERS-1:0]    BTN,
  output logic [PLAYERS*PW-1:0] POSITIONS,
  output logic [1:0]            STATE,
  output logic [WW-1:0]         WINNER,
  output logic                  UPDATE_FRAME
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_POS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RACE = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  logic [PLAYERS-1:0]    sync1_q, sync2_q, stable_q, stable_d_q, press_q;
  logic [CW-1:0]         cnt_q [PLAYERS];
  state_t                state_q, state_d;
  logic [PLAYERS*PW-1:0] pos_q, pos_d;
  logic [WW-1:0]         winner_q, winner_d;
  logic                  armed_q, armed_d;
  logic                  update_q, update_d;
  logic                  won;
  logic                  tmo_hit;

  // Release of a debounced button is filtered the same way as a press.
  always_ff @(posedge clk or posedge FORCE_RESET) begin
    if (FORCE_RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      stable_d_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < PLAYERS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= BTN;
      sync2_q    <= sync1_q;
      stable_d_q <= stable_q;
      press_q    <= stable_q & ~stable_d_q;
      for (int i = 0; i < PLAYERS; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

`ifdef LEDS_RACER_WIN_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(WIN_TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q;

  always_ff @(posedge clk or posedge FORCE_RESET) begin
    if (FORCE_RESET)           tmo_q <= '0;
    else if (state_q != ST_WIN) tmo_q <= '0;
    else                       tmo_q <= tmo_q + 32'd1;
  end

  assign tmo_hit = (state_q == ST_WIN) && (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    winner_d = winner_q;
    armed_d  = armed_q;
    won      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|press_q) state_d = ST_RACE;
      end
      ST_RACE: begin
        // Ascending scan so the lowest finishing index wins a tie.
        for (int i = 0; i < PLAYERS; i++) begin
          if (press_q[i] && pos_q[i*PW +: PW] != MAX_P) begin
            pos_d[i*PW +: PW] = pos_q[i*PW +: PW] + PW'(1);
            if (!won && (pos_q[i*PW +: PW] + PW'(1)) == MAX_P) begin
              won      = 1'b1;
              winner_d = WW'(i);
            end
          end
        end
        if (won) begin
          state_d = ST_WIN;
          armed_d = 1'b0;
        end
      end
      ST_WIN: begin
        // A press counts only after every debounced button has been seen released.
        armed_d = armed_q | ~|stable_q;
        if ((armed_q && |press_q) || tmo_hit) begin
          state_d = ST_IDLE;
          pos_d   = '0;
          armed_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    update_d = (state_d != state_q) || (pos_d != pos_q) || (winner_d != winner_q);
  end

  always_ff @(posedge clk or posedge FORCE_RESET) begin
    if (FORCE_RESET) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      winner_q <= '0;
      armed_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      winner_q <= winner_d;
      armed_q  <= armed_d;
      update_q <= update_d;
    end
  end

  assign POSITIONS    = pos_q;
  assign STATE        = state_q;
  assign WINNER       = winner_q;
  assign UPDATE_FRAME = update_q;

endmodule

// File: tb/tb_leds_racer_race_core.sv
// tb/tb_leds_racer_race_core.sv - scoreboard bench for leds_racer_race_core
`timescale 1ns/1ps
module tb_leds_racer_race_core;

  localparam int PLAYERS = 4;
  localparam int PW      = 2;
  localparam int WW      = 2;
  localparam int FW      = PLAYERS*PW + 2 + WW;

  logic                  clk = 1'b0;
  logic                  FORCE_RESET = 1'b1;
  logic [PLAYERS-1:0]    BTN = '0;
  logic [PLAYERS*PW-1:0] POSITIONS;
  logic [1:0]            STATE;
  logic [WW-1:0]         WINNER;
  logic                  UPDATE_FRAME;

  int errors  = 0;
  int checks  = 0;
  int upd_cnt = 0;
  int cyc     = 0;
  int win_cyc = 0;
  int p [PLAYERS];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] obs_q [$];

  always #5 clk = ~clk;

  leds_racer_race_core #(
    .PLAYERS(4), .MAX_POS(3), .DEBOUNCE_CYCLES(4), .WIN_TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .FORCE_RESET(FORCE_RESET), .BTN(BTN),
    .POSITIONS(POSITIONS), .STATE(STATE), .WINNER(WINNER), .UPDATE_FRAME(UPDATE_FRAME)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!FORCE_RESET && UPDATE_FRAME) begin
      obs_q.push_back({POSITIONS, STATE, WINNER});
      upd_cnt <= upd_cnt + 1;
    end
  end

  function automatic logic [FW-1:0] mk_frame(input int s, input int w);
    return {PW'(p[3]), PW'(p[2]), PW'(p[1]), PW'(p[0]), 2'(s), WW'(w)};
  endfunction

  task automatic pulse(input logic [PLAYERS-1:0] m);
    @(negedge clk);
    BTN = m;
    repeat (10) @(negedge clk);
    BTN = '0;
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    FORCE_RESET = 1'b1;
    BTN = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (POSITIONS !== '0) begin errors++; $display("FAIL reset_pos got=%h want=0", POSITIONS); end
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", STATE); end
    checks++; if (WINNER !== '0) begin errors++; $display("FAIL reset_winner got=%0d want=0", WINNER); end
    checks++; if (UPDATE_FRAME !== 1'b0) begin errors++; $display("FAIL reset_update got=%b want=0", UPDATE_FRAME); end
    @(negedge clk);
    FORCE_RESET = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency;
    int n, u0;
    logic [FW-1:0] got, want;
    @(negedge clk);
    u0 = upd_cnt;
    BTN = 4'b0100;
    for (int i = 0; i < PLAYERS; i++) p[i] = 0;
    exp_q.push_back(mk_frame(1, 0));
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (UPDATE_FRAME) begin n = i; break; end
    end
    #1;
    checks++; if (n != 8) begin errors++; $display("FAIL start_latency got=%0d want=8 negedges", n); end
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL start_frame missing obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL start_frame got=%h want=%h", got, want); end
    end
    BTN = '0;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (upd_cnt - u0 != 1) begin errors++; $display("FAIL start_single_pulse got=%0d want=1", upd_cnt - u0); end
  endtask

  task automatic test_bounce;
    int u0;
    u0 = upd_cnt;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      BTN[1] = ((c / 3) % 2) == 0;
    end
    @(negedge clk);
    BTN = '0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (POSITIONS[3:2] !== 2'd0) begin errors++; $display("FAIL bounce_pos1 got=%0d want=0", POSITIONS[3:2]); end
    checks++; if (upd_cnt != u0) begin errors++; $display("FAIL bounce_updates got=%0d want=0", upd_cnt - u0); end
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL bounce_state got=%0d want=1", STATE); end
  endtask

  task automatic test_race;
    int order [4] = '{0, 3, 0, 3};
    logic [FW-1:0] got, want;
    for (int k = 0; k < 4; k++) begin
      p[order[k]]++;
      exp_q.push_back(mk_frame(1, 0));
      pulse(4'(1 << order[k]));
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        errors++; $display("FAIL race_step%0d frames obs=%0d exp=%0d", k, obs_q.size(), exp_q.size());
        obs_q.delete(); exp_q.delete();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL race_step%0d got=%h want=%h", k, got, want); end
      end
    end
  endtask

  task automatic test_simultaneous_win;
    int n, u0;
    logic [FW-1:0] got, want;
    @(negedge clk);
    u0 = upd_cnt;
    BTN = 4'b1001;
    p[0] = 3; p[3] = 3;
    exp_q.push_back(mk_frame(2, 0));
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (UPDATE_FRAME) begin n = i; break; end
    end
    #1;
    win_cyc = cyc;
    checks++; if (n == 0) begin errors++; $display("FAIL win_wait got=timeout want=update"); end
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL win_frame missing obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL win_frame got=%h want=%h", got, want); end
    end
    BTN = 4'b0001;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (upd_cnt - u0 != 1) begin errors++; $display("FAIL win_single_pulse got=%0d want=1", upd_cnt - u0); end
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL win_state got=%0d want=2", STATE); end
  endtask

`ifndef LEDS_RACER_WIN_TIMEOUT_EN
  task automatic test_win_lockout;
    int u0, n;
    logic stay;
    logic [FW-1:0] got, want;
    u0 = upd_cnt;
    BTN = 4'b0011;
    stay = 1'b1;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (STATE !== 2'd2) stay = 1'b0;
    end
    #1;
    checks++; if (!stay) begin errors++; $display("FAIL lockout_state got=left_win want=stay_win"); end
    checks++; if (upd_cnt != u0) begin errors++; $display("FAIL lockout_updates got=%0d want=0", upd_cnt - u0); end
    BTN = '0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < PLAYERS; i++) p[i] = 0;
    exp_q.push_back(mk_frame(0, 0));
    BTN = 4'b0010;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (UPDATE_FRAME) begin n = i; break; end
    end
    #1;
    checks++; if (n == 0) begin errors++; $display("FAIL exit_wait got=timeout want=update"); end
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL exit_frame missing obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL exit_frame got=%h want=%h", got, want); end
    end
    BTN = '0;
    repeat (12) @(negedge clk);
  endtask
`else
  task automatic test_timeout;
    int n;
    logic [FW-1:0] got, want;
    BTN = '0;
    for (int i = 0; i < PLAYERS; i++) p[i] = 0;
    exp_q.push_back(mk_frame(0, 0));
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (UPDATE_FRAME) begin n = i; break; end
    end
    #1;
    checks++; if (n == 0 || cyc - win_cyc != 20) begin errors++; $display("FAIL timeout_cycles got=%0d want=20", cyc - win_cyc); end
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL timeout_frame missing obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL timeout_frame got=%h want=%h", got, want); end
    end
    repeat (12) @(negedge clk);
  endtask
`endif

  task automatic test_async_reset;
    logic [FW-1:0] got, want;
    for (int k = 0; k < 3; k++) begin
      p[1] = k;
      exp_q.push_back(mk_frame(1, 0));
      pulse(4'b0010);
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        errors++; $display("FAIL areset_step%0d frames obs=%0d exp=%0d", k, obs_q.size(), exp_q.size());
        obs_q.delete(); exp_q.delete();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL areset_step%0d got=%h want=%h", k, got, want); end
      end
    end
    @(negedge clk);
    #2;
    FORCE_RESET = 1'b1;
    #1;
    checks++; if (POSITIONS !== '0) begin errors++; $display("FAIL areset_pos got=%h want=0", POSITIONS); end
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL areset_state got=%0d want=0", STATE); end
    checks++; if (WINNER !== '0) begin errors++; $display("FAIL areset_winner got=%0d want=0", WINNER); end
    checks++; if (UPDATE_FRAME !== 1'b0) begin errors++; $display("FAIL areset_update got=%b want=0", UPDATE_FRAME); end
    repeat (3) @(negedge clk);
    FORCE_RESET = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < PLAYERS; i++) p[i] = 0;
    test_reset();
    test_latency();
    test_bounce();
    test_race();
    test_simultaneous_win();
`ifndef LEDS_RACER_WIN_TIMEOUT_EN
    test_win_lockout();
`else
    test_timeout();
`endif
    test_async_reset();
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_frames got obs=%0d exp=%0d want=0", obs_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
